// File: rtl/f33m_mult_arbiter.sv
// Shares one GF(3^{3m}) multiplier core among NREQ requesters: arbitrate, launch, wait, ack.
// Define F33M_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
`ifndef W3
`define W3 581
`endif

module f33m_mult_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*(`W3+1)-1:0]  a_bus,
  input  logic [NREQ*(`W3+1)-1:0]  b_bus,
  output logic [NREQ-1:0]          ack,
  output logic [`W3:0]             c,
  output logic                     busy,
  output logic                     mult_reset,
  output logic [`W3:0]             mult_a,
  output logic [`W3:0]             mult_b,
  input  logic [`W3:0]             mult_c,
  input  logic                     mult_done
);
  localparam int W  = `W3 + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, START, CLR, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]   grant, pick;
  logic [NREQ-1:0] cand;
  logic            found;

`ifdef F33M_ARB_FIXED_PRIO_EN
  always_comb cand = req;
`else
  logic [IW-1:0]   rr;
  logic [NREQ-1:0] hi_mask, hi_req;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    hi_mask = ~((NREQ'(1) << rr) - NREQ'(1));
    hi_req  = req & hi_mask;
    cand    = (|hi_req) ? hi_req : req;
  end
`endif

  always_comb begin
    pick  = '0;
    found = |req;
    for (int j = NREQ - 1; j >= 0; j--)
      if (cand[j]) pick = IW'(j);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = START;
      START:   state_nx = CLR;
      CLR:     state_nx = WAIT;
      WAIT:    if (mult_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack        <= '0;
      c          <= '0;
      busy       <= 1'b0;
      mult_reset <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      grant      <= '0;
`ifndef F33M_ARB_FIXED_PRIO_EN
      rr         <= '0;
`endif
    end else begin
      mult_reset <= 1'b0;
      ack        <= '0;
      case (state)
        IDLE: if (found) begin
          grant      <= pick;
          mult_a     <= a_bus[pick*W +: W];
          mult_b     <= b_bus[pick*W +: W];
          busy       <= 1'b1;
          mult_reset <= 1'b1;
        end
        // Done seen in CLR is the core's stale flag and is deliberately ignored.
        WAIT: if (mult_done) begin
          c          <= mult_c;
          ack[grant] <= 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
`ifndef F33M_ARB_FIXED_PRIO_EN
          rr   <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_f33m_mult_arbiter.sv
// Directed bench for f33m_mult_arbiter with a behavioural stand-in core (integer product, fixed latency).
`ifndef W3
`define W3 581
`endif

module tb_f33m_mult_arbiter;
  localparam int W    = `W3 + 1;
  localparam int NREQ = 2;
  localparam int LAT  = 4;

  localparam logic [W-1:0] ONE = {388'h0, 194'h1};
  localparam logic [W-1:0] XV  = {70'h2a5, 64'hdeadbeefcafef00d, 64'h0123456789abcdef,
                                  64'h55aa33cc0ff0a5a5, 64'h1, 64'hfedcba9876543210,
                                  64'h8000000000000001, 64'h0f1e2d3c4b5a6978, 64'h2468ace013579bdf};

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus, b_bus;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      c, mult_a, mult_b;
  logic [W-1:0]      mult_c = '0;
  logic              busy, mult_reset;
  logic              mult_done = 1'b0;
  int                core_cnt = 0;

  int n_chk  = 0;
  int n_pass = 0;

  f33m_mult_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .c(c), .busy(busy), .mult_reset(mult_reset),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  // Stand-in core: done clears on mult_reset, rises LAT edges later with a*b.
  always @(posedge clk) begin
    if (mult_reset) begin
      core_cnt  <= LAT;
      mult_done <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        mult_done <= 1'b1;
        mult_c    <= mult_a * mult_b;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic prev_mr = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      chk("ack_onehot0", W'($onehot0(ack)), W'(1));
      chk("mrst_one_cycle", W'(mult_reset & prev_mr), '0);
      chk("ack_with_mrst", W'((|ack) & mult_reset), '0);
    end
    prev_mr = mult_reset;
  end

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ack != '0) seen = 1;
    end
    if (!seen) chk({tag, "_timeout"}, W'(1), '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [NREQ-1:0] exp_ack;
    reset = 1'b1; req = '0; a_bus = '0; b_bus = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", W'(ack), '0);
    chk("rst_c", c, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_mrst", W'(mult_reset), '0);
    chk("rst_ma", mult_a, '0);
    chk("rst_mb", mult_b, '0);
    reset = 1'b0;

    // 1: single request, X * ONE
    a_bus[0 +: W] = XV; b_bus[0 +: W] = ONE; req = 2'b01;
    @(negedge clk);
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_mrst", W'(mult_reset), W'(1));
    chk("t1_ma", mult_a, XV);
    req = '0;
    wait_ack("t1");
    chk("t1_ack", W'(ack), W'(2'b01));
    chk("t1_c", c, XV);
    chk("t1_busy_ack", W'(busy), W'(1));
    @(negedge clk);
    chk("t1_busy_fall", W'(busy), '0);
    chk("t1_ack_fall", W'(ack), '0);

    // 2: both requesting continuously
    do_reset();
    a_bus[0 +: W] = W'(3); b_bus[0 +: W] = W'(5);
    a_bus[W +: W] = W'(7); b_bus[W +: W] = W'(11);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack("t2");
`ifdef F33M_ARB_FIXED_PRIO_EN
      exp_ack = 2'b01;
`else
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("t2_ack%0d", k), W'(ack), W'(exp_ack));
      chk($sformatf("t2_c%0d", k), c, (exp_ack == 2'b01) ? W'(15) : W'(77));
      if (k == 3) req = '0;
    end
    @(negedge clk);

    // 3: one-cycle pulse on req[1], X * 0
    a_bus[W +: W] = XV; b_bus[W +: W] = '0; req = 2'b10;
    @(negedge clk);
    req = '0;
    chk("t3_busy", W'(busy), W'(1));
    wait_ack("t3");
    chk("t3_ack", W'(ack), W'(2'b10));
    chk("t3_c", c, '0);
    @(negedge clk);

    // 4: reset while waiting on the core
    a_bus[0 +: W] = W'(5); b_bus[0 +: W] = W'(6); req = 2'b01;
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_busy", W'(busy), '0);
    chk("t4_ack", W'(ack), '0);
    chk("t4_mrst", W'(mult_reset), '0);
    chk("t4_ma", mult_a, '0);
    chk("t4_c", c, '0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack != '0) seen = 1;
    end
    chk("t4_no_ack", W'(seen), '0);
    a_bus[0 +: W] = W'(9); b_bus[0 +: W] = W'(9); req = 2'b01;
    @(negedge clk);
    req = '0;
    wait_ack("t4b");
    chk("t4b_ack", W'(ack), W'(2'b01));
    chk("t4b_c", c, W'(81));
    @(negedge clk);

    // 5: requester drops and changes operands mid-operation
    a_bus[0 +: W] = W'(13); b_bus[0 +: W] = W'(17); req = 2'b01;
    repeat (3) @(negedge clk);
    req = '0; a_bus[0 +: W] = W'(99); b_bus[0 +: W] = W'(99);
    wait_ack("t5");
    chk("t5_ack", W'(ack), W'(2'b01));
    chk("t5_c", c, W'(221));
    chk("t5_ma", mult_a, W'(13));
    @(negedge clk);
    chk("t5_idle", W'(busy), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
